// File: rtl/ft600_pkg.sv
// Shared types and constants for the FT600 transmit path.
package ft600_pkg;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_BOTH = 2'b11;

    typedef struct packed {
        logic [1:0]  be;
        logic [15:0] data;
    } ft600_word_t;

    typedef enum logic {
        IDLE = 1'b0,
        HALF = 1'b1
    } tx_pack_state_t;

endpackage

// File: rtl/ft600_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head reads zero while empty.
module ft600_sync_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers carry one extra bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (level == (AW+1)'(DEPTH));
    assign rdata = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ft600_tx_buffer.sv
// Packs user bytes little-endian into 16-bit words with byte enables and
// buffers them for the FT600 bus interface.
module ft600_tx_buffer
    import ft600_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic        ftdi_clk,
    input  logic        rst_n,
    input  logic [7:0]  s_byte,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        s_flush,
    output logic [15:0] data_to_ft600,
    output logic [1:0]  be_to_ft600,
    output logic        data_in_valid,
    input  logic        ready_to_recieve,
    output logic [AW:0] fifo_level,
    output logic        fifo_full
);

    tx_pack_state_t state_q, state_d;
    logic [7:0]     lo_q, lo_d;
    logic           flush_q, flush_d;
    logic           xfer;
    logic           flush_req;
    logic           push;
    ft600_word_t    push_word;
    ft600_word_t    head_word;
    logic           fifo_empty;

    assign s_ready   = (state_q == IDLE) || !fifo_full;
    assign xfer      = s_valid && s_ready;
    assign flush_req = s_flush || flush_q;

    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        flush_d   = flush_q;
        push      = 1'b0;
        push_word = '{be: BE_NONE, data: 16'h0000};
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (s_flush) begin
                        push      = 1'b1;
                        push_word = '{be: BE_LO, data: {8'h00, s_byte}};
                    end else begin
                        lo_d    = s_byte;
                        state_d = HALF;
                    end
                end
            end
            HALF: begin
                if (xfer) begin
                    // Completing the word absorbs any pending flush.
                    push      = 1'b1;
                    push_word = '{be: BE_BOTH, data: {s_byte, lo_q}};
                    state_d   = IDLE;
                    flush_d   = 1'b0;
                end else if (flush_req) begin
                    if (!fifo_full) begin
                        push      = 1'b1;
                        push_word = '{be: BE_LO, data: {8'h00, lo_q}};
                        state_d   = IDLE;
                        flush_d   = 1'b0;
                    end else begin
                        flush_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ftdi_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lo_q    <= 8'h00;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            flush_q <= flush_d;
        end
    end

    ft600_sync_fifo #(
        .WIDTH (18),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (ftdi_clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_word),
        .pop   (ready_to_recieve),
        .rdata (head_word),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign data_to_ft600 = head_word.data;
    assign be_to_ft600   = head_word.be;
    assign data_in_valid = !fifo_empty;

endmodule

// File: tb/tb_ft600_tx_buffer.sv
// Directed bench for ft600_tx_buffer with hand-computed expectations.
module tb_ft600_tx_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          ftdi_clk = 1'b0;
    logic          rst_n;
    logic [7:0]    s_byte;
    logic          s_valid;
    logic          s_ready;
    logic          s_flush;
    logic [15:0]   data_to_ft600;
    logic [1:0]    be_to_ft600;
    logic          data_in_valid;
    logic          ready_to_recieve;
    logic [AW:0]   fifo_level;
    logic          fifo_full;

    int vectors    = 0;
    int miscompares = 0;

    ft600_tx_buffer #(
        .DEPTH (DEPTH)
    ) dut (
        .ftdi_clk         (ftdi_clk),
        .rst_n            (rst_n),
        .s_byte           (s_byte),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_flush          (s_flush),
        .data_to_ft600    (data_to_ft600),
        .be_to_ft600      (be_to_ft600),
        .data_in_valid    (data_in_valid),
        .ready_to_recieve (ready_to_recieve),
        .fifo_level       (fifo_level),
        .fifo_full        (fifo_full)
    );

    always #5 ftdi_clk = ~ftdi_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ftdi_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic fl);
        s_byte  = b;
        s_valid = 1'b1;
        s_flush = fl;
        tick();
        s_valid = 1'b0;
        s_flush = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  32'(data_to_ft600), 32'h0);
        check({tag, "_be"},    32'(be_to_ft600),   32'h0);
        check({tag, "_valid"}, 32'(data_in_valid), 32'h0);
        check({tag, "_full"},  32'(fifo_full),     32'h0);
        check({tag, "_ready"}, 32'(s_ready),       32'h1);
        check({tag, "_level"}, 32'(fifo_level),    32'h0);
    endtask

    initial begin
        logic [7:0]  bytes4 [4];
        logic [15:0] exp_word;
        int          words;

        rst_n            = 1'b0;
        s_byte           = 8'h00;
        s_valid          = 1'b0;
        s_flush          = 1'b0;
        ready_to_recieve = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Four bytes packed into two words.
        bytes4[0] = 8'h11; bytes4[1] = 8'h22; bytes4[2] = 8'h33; bytes4[3] = 8'h44;
        for (int i = 0; i < 4; i++) send(bytes4[i], 1'b0);
        check("pack_level", 32'(fifo_level), 32'd2);
        check("pack_head",  32'(data_to_ft600), 32'h2211);
        check("pack_be",    32'(be_to_ft600), 32'h3);
        check("pack_valid", 32'(data_in_valid), 32'h1);
        ready_to_recieve = 1'b1;
        tick();
        check("pop1_head",  32'(data_to_ft600), 32'h4433);
        check("pop1_level", 32'(fifo_level), 32'd1);
        tick();
        check("pop2_valid", 32'(data_in_valid), 32'h0);
        check("pop2_data",  32'(data_to_ft600), 32'h0);
        check("pop2_be",    32'(be_to_ft600), 32'h0);
        ready_to_recieve = 1'b0;

        // Odd byte followed by a separate flush pulse.
        send(8'hA5, 1'b0);
        check("half_level", 32'(fifo_level), 32'd0);
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        check("flush_level", 32'(fifo_level), 32'd1);
        check("flush_data",  32'(data_to_ft600), 32'h00A5);
        check("flush_be",    32'(be_to_ft600), 32'h1);
        ready_to_recieve = 1'b1;
        tick();
        ready_to_recieve = 1'b0;
        check("flush_drained", 32'(fifo_level), 32'd0);

        // Byte and flush in the same cycle.
        send(8'h5A, 1'b1);
        check("sameflush_level", 32'(fifo_level), 32'd1);
        check("sameflush_data",  32'(data_to_ft600), 32'h005A);
        check("sameflush_be",    32'(be_to_ft600), 32'h1);
        ready_to_recieve = 1'b1;
        tick();
        ready_to_recieve = 1'b0;
        check("sameflush_drained", 32'(fifo_level), 32'd0);

        // Fill to DEPTH, then a held flush while full.
        for (int i = 0; i < 2 * DEPTH; i++) send(8'(i), 1'b0);
        check("fill_level", 32'(fifo_level), 32'(DEPTH));
        check("fill_full",  32'(fifo_full), 32'h1);
        check("fill_ready_idle", 32'(s_ready), 32'h1);
        check("fill_head", 32'(data_to_ft600), 32'h0100);
        send(8'hEE, 1'b0);
        check("full_half_ready", 32'(s_ready), 32'h0);
        s_flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_flush_hold", 32'(fifo_level), 32'(DEPTH));
        end
        ready_to_recieve = 1'b1;
        tick();
        ready_to_recieve = 1'b0;
        check("full_pop_level", 32'(fifo_level), 32'(DEPTH - 1));
        check("full_pop_full",  32'(fifo_full), 32'h0);
        tick();
        s_flush = 1'b0;
        check("full_flush_exec", 32'(fifo_level), 32'(DEPTH));
        check("full_flush_full", 32'(fifo_full), 32'h1);
        check("full_flush_ready", 32'(s_ready), 32'h1);
        ready_to_recieve = 1'b1;
        for (int k = 1; k < DEPTH; k++) begin
            exp_word = {8'(2 * k + 1), 8'(2 * k)};
            check("drain_data", 32'(data_to_ft600), 32'(exp_word));
            check("drain_be",   32'(be_to_ft600), 32'h3);
            tick();
        end
        check("drain_last_data", 32'(data_to_ft600), 32'h00EE);
        check("drain_last_be",   32'(be_to_ft600), 32'h1);
        tick();
        check("drain_empty", 32'(data_in_valid), 32'h0);

        // Streaming across pointer wrap with the consumer always ready.
        words = 0;
        s_valid = 1'b1;
        for (int j = 0; j < 2 * (2 * DEPTH + 3); j++) begin
            s_byte = 8'(j);
            tick();
            if (data_in_valid) begin
                exp_word = {8'(2 * words + 1), 8'(2 * words)};
                check("stream_data", 32'(data_to_ft600), 32'(exp_word));
                words++;
            end
            check("stream_level_le1", 32'(fifo_level <= 1), 32'h1);
        end
        s_valid = 1'b0;
        tick();
        check("stream_words", 32'(words), 32'(2 * DEPTH + 3));
        check("stream_empty", 32'(data_in_valid), 32'h0);
        ready_to_recieve = 1'b0;

        // Asynchronous reset mid-packet.
        for (int i = 0; i < 11; i++) send(8'(8'hC0 + i), 1'b0);
        check("prereset_level", 32'(fifo_level), 32'd5);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        check("postreset_level", 32'(fifo_level), 32'd1);
        check("postreset_data",  32'(data_to_ft600), 32'h8877);
        check("postreset_be",    32'(be_to_ft600), 32'h3);
        ready_to_recieve = 1'b1;
        tick();

        // Consumer ready while empty: no underflow.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("underflow_level", 32'(fifo_level), 32'd0);
            check("underflow_valid", 32'(data_in_valid), 32'h0);
        end
        ready_to_recieve = 1'b0;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        check("after_underflow_level", 32'(fifo_level), 32'd1);
        check("after_underflow_data",  32'(data_to_ft600), 32'h0201);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
